// File: rtl/hazard_ctrl_if.sv
// Port bundle for hazard_ctrl: hazard inputs from ID/EX/MEM and the pipeline
// register enable/flush controls back to the datapath.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  // Memory handshake: the MEM access completes in the cycle where mem_req_i and
  // mem_ready_i are both 1; while mem_req_i=1 and mem_ready_i=0 the whole pipe holds.
  logic [4:0]       id_rs1_addr_i;
  logic [4:0]       id_rs2_addr_i;
  logic             id_is_rs1_i;
  logic             id_is_rs2_i;
  logic [4:0]       ex_rd_addr_i;
  logic             ex_rd_wren_i;
  logic             ex_is_load_i;
  logic             br_taken_i;
  logic             mem_req_i;
  logic             mem_ready_i;

  logic             pc_en_o;
  logic             ifid_en_o;
  logic             ifid_flush_o;
  logic             idex_en_o;
  logic             idex_flush_o;
  logic             exmem_en_o;
  logic             exmem_flush_o;
  logic             mem_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [1:0]       dbg_state_o;

  modport master (
    output id_rs1_addr_i, id_rs2_addr_i, id_is_rs1_i, id_is_rs2_i,
           ex_rd_addr_i, ex_rd_wren_i, ex_is_load_i, br_taken_i,
           mem_req_i, mem_ready_i,
    input  pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o,
           exmem_en_o, exmem_flush_o, mem_timeout_o, stall_cnt_o, dbg_state_o
  );

  modport slave (
    input  id_rs1_addr_i, id_rs2_addr_i, id_is_rs1_i, id_is_rs2_i,
           ex_rd_addr_i, ex_rd_wren_i, ex_is_load_i, br_taken_i,
           mem_req_i, mem_ready_i,
    output pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o,
           exmem_en_o, exmem_flush_o, mem_timeout_o, stall_cnt_o, dbg_state_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: boot flush,
// load-use bubbles, branch redirects, memory wait states and a timeout trap.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic             boot_q, boot_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             timeout_q, timeout_d;

  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush;
  logic release_run;
  logic rs1_hit, rs2_hit, load_use, mem_stall;

  assign rs1_hit   = bus.id_is_rs1_i && (bus.id_rs1_addr_i == bus.ex_rd_addr_i);
  assign rs2_hit   = bus.id_is_rs2_i && (bus.id_rs2_addr_i == bus.ex_rd_addr_i);
  assign load_use  = bus.ex_is_load_i && bus.ex_rd_wren_i && (bus.ex_rd_addr_i != 5'd0)
                     && (rs1_hit || rs2_hit);
  assign mem_stall = bus.mem_req_i && !bus.mem_ready_i;

  always_comb begin
    state_d     = state_q;
    boot_d      = boot_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    release_run = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        ifid_en     = 1'b1;
        ifid_flush  = 1'b1;
        idex_en     = 1'b1;
        idex_flush  = 1'b1;
        exmem_en    = 1'b1;
        exmem_flush = 1'b1;
        boot_d      = 1'b1;
        if (boot_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mem_stall) begin
          wait_cnt_d = 8'd1;
          state_d    = ST_WAIT;
        end else begin
          release_run = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!bus.mem_ready_i) begin
          if (wait_cnt_q == TIMEOUT_C) begin
            state_d   = ST_ERR;
            timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          // Branch and hazard inputs were frozen during the wait, so they still apply.
          release_run = 1'b1;
          state_d     = ST_RUN;
        end
      end
      ST_ERR: begin
      end
      default: state_d = ST_BOOT;
    endcase

    if (release_run) begin
      if (bus.br_taken_i) begin
        // The ID instruction is killed, so a pending load-use hazard is irrelevant.
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
      end else if (load_use) begin
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_RUN || state_q == ST_WAIT) && !pc_en && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_BOOT;
      boot_q      <= 1'b0;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_q      <= boot_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.pc_en_o       = pc_en;
  assign bus.ifid_en_o     = ifid_en;
  assign bus.ifid_flush_o  = ifid_flush;
  assign bus.idex_en_o     = idex_en;
  assign bus.idex_flush_o  = idex_flush;
  assign bus.exmem_en_o    = exmem_en;
  assign bus.exmem_flush_o = exmem_flush;
  assign bus.mem_timeout_o = timeout_q;
  assign bus.stall_cnt_o   = stall_cnt_q;
  assign bus.dbg_state_o   = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default-parameter instance and a small
// instance (MEM_TIMEOUT=4, CNT_W=3) for timeout and saturation.
module tb_hazard_ctrl;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, mem_timeout}
  localparam logic [7:0] BOOT_C  = 8'b0111_1110;
  localparam logic [7:0] NORM_C  = 8'b1101_0100;
  localparam logic [7:0] STALL_C = 8'b0000_0000;
  localparam logic [7:0] LU_C    = 8'b0001_1100;
  localparam logic [7:0] BR_C    = 8'b1111_1100;
  localparam logic [7:0] ERR_C   = 8'b0000_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  hazard_ctrl_if #(.CNT_W(32)) ifa ();
  hazard_ctrl_if #(.CNT_W(3))  ifb ();

  hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(32)) dut_a (
    .clk_i   (clk),
    .reset_i (rst_a),
    .bus     (ifa.slave)
  );

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut_b (
    .clk_i   (clk),
    .reset_i (rst_b),
    .bus     (ifb.slave)
  );

  int total = 0;
  int bad   = 0;
  bit sel   = 1'b0;

  logic [4:0] in_rs1, in_rs2, in_rd;
  logic       in_is_rs1, in_is_rs2, in_wren, in_load, in_br, in_req, in_rdy;

  logic [39:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] exp_cnt;

  function automatic logic [31:0] cnt_max();
    return sel ? 32'd7 : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_in();
    in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
    in_is_rs1 = 1'b0; in_is_rs2 = 1'b0; in_wren = 1'b0; in_load = 1'b0;
    in_br = 1'b0; in_req = 1'b0; in_rdy = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs2);
    in_load = 1'b1; in_wren = 1'b1; in_rd = rd; in_rs2 = rs2; in_is_rs2 = 1'b1;
  endtask

  task automatic apply();
    if (!sel) begin
      ifa.id_rs1_addr_i = in_rs1; ifa.id_rs2_addr_i = in_rs2;
      ifa.id_is_rs1_i = in_is_rs1; ifa.id_is_rs2_i = in_is_rs2;
      ifa.ex_rd_addr_i = in_rd; ifa.ex_rd_wren_i = in_wren; ifa.ex_is_load_i = in_load;
      ifa.br_taken_i = in_br; ifa.mem_req_i = in_req; ifa.mem_ready_i = in_rdy;
    end else begin
      ifb.id_rs1_addr_i = in_rs1; ifb.id_rs2_addr_i = in_rs2;
      ifb.id_is_rs1_i = in_is_rs1; ifb.id_is_rs2_i = in_is_rs2;
      ifb.ex_rd_addr_i = in_rd; ifb.ex_rd_wren_i = in_wren; ifb.ex_is_load_i = in_load;
      ifb.br_taken_i = in_br; ifb.mem_req_i = in_req; ifb.mem_ready_i = in_rdy;
    end
  endtask

  function automatic logic [7:0] obs_ctrl();
    if (!sel)
      return {ifa.pc_en_o, ifa.ifid_en_o, ifa.ifid_flush_o, ifa.idex_en_o,
              ifa.idex_flush_o, ifa.exmem_en_o, ifa.exmem_flush_o, ifa.mem_timeout_o};
    return {ifb.pc_en_o, ifb.ifid_en_o, ifb.ifid_flush_o, ifb.idex_en_o,
            ifb.idex_flush_o, ifb.exmem_en_o, ifb.exmem_flush_o, ifb.mem_timeout_o};
  endfunction

  function automatic logic [31:0] obs_cnt();
    return sel ? 32'(ifb.stall_cnt_o) : ifa.stall_cnt_o;
  endfunction

  task automatic check();
    logic [39:0] e;
    string       t;
    logic [7:0]  oc;
    logic [31:0] ocnt;
    e    = exp_q.pop_front();
    t    = tag_q.pop_front();
    oc   = obs_ctrl();
    ocnt = obs_cnt();
    total++;
    assert (oc === e[39:32]) else begin
      bad++;
      $error("FAIL %s ctrl: got %b expected %b", t, oc, e[39:32]);
    end
    total++;
    assert (ocnt === e[31:0]) else begin
      bad++;
      $error("FAIL %s stall_cnt: got %0d expected %0d", t, ocnt, e[31:0]);
    end
  endtask

  // Caller is aligned on a falling edge; returns aligned on the next one.
  task automatic step(input string tag, input logic [7:0] ctrl);
    apply();
    exp_q.push_back({ctrl, exp_cnt});
    tag_q.push_back(tag);
    #1;
    check();
    if (ctrl != BOOT_C && ctrl != ERR_C && !ctrl[7] && exp_cnt < cnt_max())
      exp_cnt = exp_cnt + 32'd1;
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    if (sel) rst_b = 1'b1; else rst_a = 1'b1;
    exp_cnt = 32'd0;
    clear_in();
    apply();
    exp_q.push_back({BOOT_C, exp_cnt});
    tag_q.push_back(tag);
    #1;
    check();
    @(negedge clk);
    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
    step("boot0", BOOT_C);
    step("boot1", BOOT_C);
    step("run0", NORM_C);
  endtask

  initial begin
    clear_in();
    sel = 1'b1; apply();
    sel = 1'b0; apply();
    exp_cnt = 32'd0;

    // Default instance
    do_reset("reset_a");

    set_load_use(5'd5, 5'd5);
    step("lu_rs2", LU_C);
    clear_in();
    step("lu_after", NORM_C);
    set_load_use(5'd0, 5'd0);
    step("lu_x0", NORM_C);
    clear_in();
    in_load = 1'b1; in_wren = 1'b1; in_rd = 5'd7; in_rs1 = 5'd7; in_is_rs1 = 1'b1;
    step("lu_rs1", LU_C);
    in_is_rs1 = 1'b0;
    step("lu_rs1_unused", NORM_C);
    set_load_use(5'd9, 5'd9); in_wren = 1'b0;
    step("lu_no_wren", NORM_C);
    set_load_use(5'd9, 5'd9); in_load = 1'b0;
    step("lu_not_load", NORM_C);

    clear_in();
    set_load_use(5'd5, 5'd5); in_br = 1'b1;
    step("br_hazard", BR_C);
    clear_in();
    step("br_after", NORM_C);

    in_req = 1'b1; in_rdy = 1'b1;
    step("mem_ready_now", NORM_C);
    in_rdy = 1'b0; in_br = 1'b1;
    step("mw_run", STALL_C);
    step("mw_w1", STALL_C);
    step("mw_w2", STALL_C);
    in_rdy = 1'b1;
    step("mw_release_br", BR_C);
    clear_in();
    step("mw_after", NORM_C);

    in_req = 1'b1; set_load_use(5'd3, 5'd3);
    step("mwlu_run", STALL_C);
    in_rdy = 1'b1;
    step("mwlu_release", LU_C);
    clear_in();
    step("mwlu_after", NORM_C);

    in_req = 1'b1;
    step("mwrst_run", STALL_C);
    step("mwrst_w1", STALL_C);
    do_reset("reset_mid_wait");

    // Small instance: MEM_TIMEOUT=4, CNT_W=3
    sel = 1'b1;
    do_reset("reset_b");
    for (int i = 0; i < 10; i++) begin
      set_load_use(5'd12, 5'd12);
      step("sat_lu", LU_C);
      clear_in();
      step("sat_norm", NORM_C);
    end

    do_reset("reset_b2");
    in_req = 1'b1;
    for (int i = 0; i < 4; i++) step("edge_wait", STALL_C);
    in_rdy = 1'b1;
    step("edge_release", NORM_C);
    clear_in();
    step("edge_after", NORM_C);

    in_req = 1'b1;
    for (int i = 0; i < 5; i++) step("to_wait", STALL_C);
    step("to_err", ERR_C);
    in_rdy = 1'b1; in_br = 1'b1;
    step("to_sticky", ERR_C);
    clear_in();
    step("to_sticky2", ERR_C);
    do_reset("reset_clears_to");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
